// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory bus responder: FSM state encoding,
// wait-counter width and small arithmetic helpers.
package mem_bus_responder_pkg;

  localparam int RESP_WAIT_W = 4;

  localparam logic [RESP_WAIT_W-1:0] WAIT_ZERO = 4'd0;
  localparam logic [RESP_WAIT_W-1:0] WAIT_ONE  = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } resp_state_e;

  // Saturating 16-bit increment used by the transfer counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/mem_bus_responder_ram.sv
// Single-port synchronous RAM, DATA_W x 2**DEPTH_LOG2 words, with a
// registered read port. Contents are intentionally not reset.
module mem_bus_responder_ram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_r [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_r;

  // Storage array: write on enable+we, read data registered on every enable.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= wdata;
      end
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_bus_responder.sv
// Target-side responder on the CPU external memory bus. Claims a fixed
// word-address window, inserts WAIT_CYC wait states and completes each
// transfer with a four-phase read_dn/write_dn handshake.
// Optional build macro: MEM_BUS_RESPONDER_STATS_EN adds saturating
// rd_cnt/wr_cnt completed-transfer counters.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
  parameter int                DEPTH_LOG2 = 8,
  parameter int                WAIT_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_oe,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_q,
  input  logic              write_q,
  output logic [DATA_W-1:0] data_out,
  output logic              read_dn,
  output logic              write_dn,
  output logic              bus_busy_out
`ifdef MEM_BUS_RESPONDER_STATS_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
`endif
);

  resp_state_e             state_r;
  logic [RESP_WAIT_W-1:0]  cnt_r;
  logic [DEPTH_LOG2-1:0]   idx_r;
  logic [DATA_W-1:0]       wdata_r;
  logic                    dir_wr_r;
  logic [DATA_W-1:0]       data_out_r;
  logic                    read_dn_r;
  logic                    write_dn_r;
  logic                    busy_r;

  logic [ADDR_W-1:0]       offset_s;
  logic                    hit_s;
  logic                    served_req_s;
  logic                    ack_entry_s;
  logic                    ram_we_s;
  logic [DATA_W-1:0]       ram_rdata_s;

  // Window decode: unsigned offset from BASE_ADDR, below-base wraps to a miss.
  assign offset_s = addr_in - BASE_ADDR;
  assign hit_s    = (offset_s[ADDR_W-1:DEPTH_LOG2] == {(ADDR_W-DEPTH_LOG2){1'b0}});

  // Request line of the transfer in progress and the WAIT->ACK transition.
  always_comb begin
    served_req_s = 1'b0;
    ack_entry_s  = 1'b0;
    ram_we_s     = 1'b0;
    if (dir_wr_r) begin
      served_req_s = write_q;
    end else begin
      served_req_s = read_q;
    end
    if (rst_n && clk_oe && (state_r == ST_WAIT) && (cnt_r == WAIT_ZERO) && served_req_s) begin
      ack_entry_s = 1'b1;
      ram_we_s    = dir_wr_r;
    end else begin
      ack_entry_s = 1'b0;
      ram_we_s    = 1'b0;
    end
  end

  mem_bus_responder_ram #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .en   (ack_entry_s),
    .we   (ram_we_s),
    .addr (idx_r),
    .wdata(wdata_r),
    .rdata(ram_rdata_s)
  );

  // Transfer FSM with registered handshake outputs; holds while clk_oe=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= WAIT_ZERO;
      idx_r      <= {DEPTH_LOG2{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      dir_wr_r   <= 1'b0;
      data_out_r <= {DATA_W{1'b0}};
      read_dn_r  <= 1'b0;
      write_dn_r <= 1'b0;
      busy_r     <= 1'b0;
    end else if (clk_oe) begin
      case (state_r)
        ST_IDLE: begin
          if ((read_q ^ write_q) && hit_s) begin
            idx_r    <= offset_s[DEPTH_LOG2-1:0];
            wdata_r  <= data_in;
            dir_wr_r <= write_q;
            cnt_r    <= RESP_WAIT_W'(WAIT_CYC);
            busy_r   <= 1'b1;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!served_req_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_RELEASE;
          end else if (cnt_r == WAIT_ZERO) begin
            state_r <= ST_ACK;
          end else begin
            cnt_r <= cnt_r - WAIT_ONE;
          end
        end
        ST_ACK: begin
          if (!served_req_s) begin
            read_dn_r  <= 1'b0;
            write_dn_r <= 1'b0;
            data_out_r <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            state_r    <= ST_RELEASE;
          end else if (dir_wr_r) begin
            write_dn_r <= 1'b1;
          end else begin
            read_dn_r  <= 1'b1;
            data_out_r <= ram_rdata_s;
          end
        end
        ST_RELEASE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out     = data_out_r;
  assign read_dn      = read_dn_r;
  assign write_dn     = write_dn_r;
  assign bus_busy_out = busy_r;

`ifdef MEM_BUS_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_r;
  logic [15:0] wr_cnt_r;

  // Completed-transfer counters, bumped on the ACK entry edge, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_r <= 16'd0;
      wr_cnt_r <= 16'd0;
    end else if (ack_entry_s) begin
      if (dir_wr_r) begin
        wr_cnt_r <= sat_inc16(wr_cnt_r);
      end else begin
        rd_cnt_r <= sat_inc16(rd_cnt_r);
      end
    end
  end

  assign rd_cnt = rd_cnt_r;
  assign wr_cnt = wr_cnt_r;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder (WAIT_CYC=2 instance
// plus a WAIT_CYC=0 instance). Honors MEM_BUS_RESPONDER_STATS_EN.
module tb_mem_bus_responder;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_oe = 1'b1;
  logic [31:0] addr = 32'd0, data_in = 32'd0;
  logic        read_q = 1'b0, write_q = 1'b0;
  logic [31:0] data_out;
  logic        read_dn, write_dn, busy;
  logic [31:0] addr0 = 32'd0, data0 = 32'd0;
  logic        rq0 = 1'b0, wq0 = 1'b0;
  logic [31:0] dout0;
  logic        rdn0, wdn0, busy0;
`ifdef MEM_BUS_RESPONDER_STATS_EN
  logic [15:0] rd_cnt, wr_cnt, rd_cnt0, wr_cnt0;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.BASE_ADDR(BASE), .WAIT_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_oe(clk_oe), .addr_in(addr), .data_in(data_in),
    .read_q(read_q), .write_q(write_q), .data_out(data_out), .read_dn(read_dn),
    .write_dn(write_dn), .bus_busy_out(busy)
`ifdef MEM_BUS_RESPONDER_STATS_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  mem_bus_responder #(.BASE_ADDR(BASE), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clk_oe(clk_oe), .addr_in(addr0), .data_in(data0),
    .read_q(rq0), .write_q(wq0), .data_out(dout0), .read_dn(rdn0),
    .write_dn(wdn0), .bus_busy_out(busy0)
`ifdef MEM_BUS_RESPONDER_STATS_EN
    , .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
`endif
  );

  // One clock: outputs settle after posedge, sampled at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count enabled edges until u_dut raises a dn (n=-1 on timeout).
  task automatic wait_dn(input bit toggle_oe, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (toggle_oe) clk_oe = ~clk_oe;
      step();
      if (clk_oe) n++;
      if (read_dn || write_dn) found = 1'b1;
    end
    if (!found) n = -1;
  endtask

  // Same as wait_dn for the WAIT_CYC=0 instance.
  task automatic wait_dn0(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      n++;
      if (rdn0 || wdn0) found = 1'b1;
    end
    if (!found) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vec_cnt++; if (data_out !== 32'd0) begin err_cnt++; $display("FAIL reset_data_out: got %h want %h", data_out, 32'd0); end
    vec_cnt++; if (read_dn !== 1'b0) begin err_cnt++; $display("FAIL reset_read_dn: got %b want 0", read_dn); end
    vec_cnt++; if (write_dn !== 1'b0) begin err_cnt++; $display("FAIL reset_write_dn: got %b want 0", write_dn); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++; if (busy0 !== 1'b0) begin err_cnt++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    int n;
    addr = BASE + 32'd5; data_in = 32'hDEADBEEF; write_q = 1'b1;
    wait_dn(1'b0, n);
    vec_cnt++; if (n !== 5) begin err_cnt++; $display("FAIL wr_latency: got %0d want 5", n); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL wr_busy: got %b want 1", busy); end
    vec_cnt++; if (read_dn !== 1'b0) begin err_cnt++; $display("FAIL wr_no_read_dn: got %b want 0", read_dn); end
    data_in = 32'h0; addr = BASE + 32'd9;
    step(); step();
    vec_cnt++; if (write_dn !== 1'b1) begin err_cnt++; $display("FAIL wr_hold: got %b want 1", write_dn); end
    write_q = 1'b0;
    step();
    vec_cnt++; if (write_dn !== 1'b0) begin err_cnt++; $display("FAIL wr_release: got %b want 0", write_dn); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL wr_busy_release: got %b want 0", busy); end
    step();
    addr = BASE + 32'd5; read_q = 1'b1;
    wait_dn(1'b0, n);
    vec_cnt++; if (n !== 5) begin err_cnt++; $display("FAIL rd_latency: got %0d want 5", n); end
    vec_cnt++; if (data_out !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL rd_data: got %h want deadbeef", data_out); end
    addr = BASE + 32'd9;
    step();
    vec_cnt++; if (data_out !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL rd_data_hold: got %h want deadbeef", data_out); end
    read_q = 1'b0;
    step();
    vec_cnt++; if (data_out !== 32'd0) begin err_cnt++; $display("FAIL rd_data_clear: got %h want 0", data_out); end
    vec_cnt++; if (read_dn !== 1'b0) begin err_cnt++; $display("FAIL rd_release: got %b want 0", read_dn); end
    step();
  endtask

  task automatic test_out_of_window();
    logic [31:0] miss_addr [2];
    bit seen;
    miss_addr[0] = BASE + 32'd256;
    miss_addr[1] = BASE - 32'd1;
    for (int k = 0; k < 2; k++) begin
      addr = miss_addr[k]; read_q = 1'b1; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (busy || read_dn || write_dn) seen = 1'b1;
      end
      vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL miss_%0d addr %h: response seen %b want 0", k, addr, seen); end
      read_q = 1'b0;
      step();
    end
  endtask

  task automatic test_simultaneous();
    int n;
    bit seen;
    addr = BASE + 32'd5; read_q = 1'b1; write_q = 1'b1; data_in = 32'h0BAD_0BAD; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy || read_dn || write_dn) seen = 1'b1;
    end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL both_req: response seen %b want 0", seen); end
    write_q = 1'b0;
    wait_dn(1'b0, n);
    vec_cnt++; if (n !== 5) begin err_cnt++; $display("FAIL both_then_rd_latency: got %0d want 5", n); end
    vec_cnt++; if (data_out !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL both_then_rd_data: got %h want deadbeef", data_out); end
    read_q = 1'b0;
    step(); step();
  endtask

  task automatic test_early_withdraw();
    int n;
    bit seen;
    addr = BASE + 32'd5; data_in = 32'h0000_1234; write_q = 1'b1;
    step();
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL wd_capture_busy: got %b want 1", busy); end
    step();
    write_q = 1'b0; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (write_dn) seen = 1'b1;
    end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL wd_no_write_dn: seen %b want 0", seen); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL wd_busy: got %b want 0", busy); end
    read_q = 1'b1;
    wait_dn(1'b0, n);
    vec_cnt++; if (data_out !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL wd_not_committed: got %h want deadbeef", data_out); end
    read_q = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_in_ack();
    int n;
    addr = BASE + 32'd5; read_q = 1'b1;
    wait_dn(1'b0, n);
    vec_cnt++; if (read_dn !== 1'b1) begin err_cnt++; $display("FAIL rst_ack_pre: got %b want 1", read_dn); end
    rst_n = 1'b0;
    step();
    vec_cnt++; if (read_dn !== 1'b0) begin err_cnt++; $display("FAIL rst_ack_read_dn: got %b want 0", read_dn); end
    vec_cnt++; if (data_out !== 32'd0) begin err_cnt++; $display("FAIL rst_ack_data: got %h want 0", data_out); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_ack_busy: got %b want 0", busy); end
`ifdef MEM_BUS_RESPONDER_STATS_EN
    vec_cnt++; if (rd_cnt !== 16'd0) begin err_cnt++; $display("FAIL rst_ack_rd_cnt: got %0d want 0", rd_cnt); end
    vec_cnt++; if (wr_cnt !== 16'd0) begin err_cnt++; $display("FAIL rst_ack_wr_cnt: got %0d want 0", wr_cnt); end
`endif
    rst_n = 1'b1;
    wait_dn(1'b0, n);
    vec_cnt++; if (n !== 5) begin err_cnt++; $display("FAIL rst_idle_latency: got %0d want 5", n); end
    vec_cnt++; if (data_out !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL rst_ram_kept: got %h want deadbeef", data_out); end
    exp_rd = 1; exp_wr = 0;
    read_q = 1'b0;
    step(); step();
  endtask

  task automatic test_clk_oe();
    int n;
    addr = BASE + 32'd7; data_in = 32'hA5A5_0001; write_q = 1'b1;
    wait_dn(1'b1, n);
    vec_cnt++; if (n !== 5) begin err_cnt++; $display("FAIL oe_wr_latency: got %0d want 5", n); end
    clk_oe = 1'b0; write_q = 1'b0;
    step(); step(); step();
    vec_cnt++; if (write_dn !== 1'b1) begin err_cnt++; $display("FAIL oe_hold_dn: got %b want 1", write_dn); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL oe_hold_busy: got %b want 1", busy); end
    clk_oe = 1'b1;
    step();
    vec_cnt++; if (write_dn !== 1'b0) begin err_cnt++; $display("FAIL oe_release: got %b want 0", write_dn); end
    step();
    read_q = 1'b1;
    wait_dn(1'b1, n);
    vec_cnt++; if (n !== 5) begin err_cnt++; $display("FAIL oe_rd_latency: got %0d want 5", n); end
    vec_cnt++; if (data_out !== 32'hA5A5_0001) begin err_cnt++; $display("FAIL oe_rd_data: got %h want a5a50001", data_out); end
    clk_oe = 1'b1; read_q = 1'b0;
    step(); step();
    exp_rd++; exp_wr++;
  endtask

  task automatic test_wait0();
    int n;
    addr0 = BASE + 32'd1; data0 = 32'h0000_0055; wq0 = 1'b1;
    wait_dn0(n);
    vec_cnt++; if (n !== 3) begin err_cnt++; $display("FAIL w0_wr_latency: got %0d want 3", n); end
    wq0 = 1'b0;
    step(); step();
    rq0 = 1'b1;
    wait_dn0(n);
    vec_cnt++; if (n !== 3) begin err_cnt++; $display("FAIL w0_rd_latency: got %0d want 3", n); end
    vec_cnt++; if (dout0 !== 32'h0000_0055) begin err_cnt++; $display("FAIL w0_rd_data: got %h want 00000055", dout0); end
    rq0 = 1'b0;
    step();
    vec_cnt++; if (dout0 !== 32'd0) begin err_cnt++; $display("FAIL w0_rd_clear: got %h want 0", dout0); end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    addr = BASE + 32'd6; data_in = 32'hCAFE_F00D; write_q = 1'b1;
    wait_dn(1'b0, n);
    write_q = 1'b0; addr = BASE + 32'd5; read_q = 1'b1;
    wait_dn(1'b0, n);
    vec_cnt++; if (n !== 7) begin err_cnt++; $display("FAIL b2b_rd5_latency: got %0d want 7", n); end
    vec_cnt++; if (data_out !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL b2b_rd5_data: got %h want deadbeef", data_out); end
    read_q = 1'b0;
    step();
    addr = BASE + 32'd6; read_q = 1'b1;
    wait_dn(1'b0, n);
    vec_cnt++; if (n !== 6) begin err_cnt++; $display("FAIL b2b_rd6_latency: got %0d want 6", n); end
    vec_cnt++; if (data_out !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL b2b_rd6_data: got %h want cafef00d", data_out); end
    read_q = 1'b0;
    step(); step();
    exp_wr++; exp_rd += 2;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_out_of_window();
    test_simultaneous();
    test_early_withdraw();
    test_reset_in_ack();
    test_clk_oe();
    test_wait0();
    test_back_to_back();
`ifdef MEM_BUS_RESPONDER_STATS_EN
    vec_cnt++; if (rd_cnt !== 16'(exp_rd)) begin err_cnt++; $display("FAIL stats_rd_cnt: got %0d want %0d", rd_cnt, exp_rd); end
    vec_cnt++; if (wr_cnt !== 16'(exp_wr)) begin err_cnt++; $display("FAIL stats_wr_cnt: got %0d want %0d", wr_cnt, exp_wr); end
    vec_cnt++; if (rd_cnt0 !== 16'd1) begin err_cnt++; $display("FAIL stats_rd_cnt0: got %0d want 1", rd_cnt0); end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Target-side end of the CPU external memory bus. Answers the read_q/write_q requests issued by a CPU core, using a local word-addressed RAM.
- Decodes a fixed address window and inserts programmable wait states.
- Completes each transfer with a four-phase read_dn/write_dn handshake.
- Sits on the shared bus next to other responders. Addresses outside its window are ignored so another responder can claim them.

Parameters:
- ADDR_W, 32, address bus width; matches ADDR_SIZE.
- DATA_W, 32, data bus width; matches DATA_SIZE.
- BASE_ADDR, 0, first word address of the window.
- DEPTH_LOG2, 8, log2 of the RAM depth in words (256 words).
- WAIT_CYC, 2, wait states between request capture and dn assertion; range 0..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- clk_oe  in  1  clock qualifier; the FSM advances only on cycles where clk_oe=1.
- addr_in  in  ADDR_W  request address from the CPU.
- data_in  in  DATA_W  write data from the CPU.
- read_q  in  1  read request level.
- write_q  in  1  write request level.
- data_out  out  DATA_W  read data; valid while read_dn=1, else 0.
- read_dn  out  1  read done.
- write_dn  out  1  write done.
- bus_busy_out  out  1  high from request capture until dn is released.

Behaviour:
- Reset: when rst_n=0 at a clk edge:
  - FSM goes to IDLE.
  - data_out=0, read_dn=0, write_dn=0, bus_busy_out=0.
  - Wait counter is cleared.
  - RAM contents are not cleared.
  - Reset mid-transfer aborts the transfer; a pending write that has not reached ACK is not committed.
- Address hit: (addr_in - BASE_ADDR) < 2**DEPTH_LOG2, computed unsigned at ADDR_W bits. The RAM index is the low DEPTH_LOG2 bits of the difference. Wrap-around below BASE_ADDR is a miss.
- IDLE state:
  - If exactly one of read_q/write_q is 1 and the address hits: latch addr, data and direction, load the wait counter with WAIT_CYC, set bus_busy_out=1, go to WAIT.
  - If read_q and write_q are both 1, or the address misses: remain in IDLE and drive nothing.
- WAIT state:
  - Decrement the counter each enabled cycle.
  - When the counter is 0, go to ACK. With WAIT_CYC=0, WAIT lasts one cycle.
- ACK state:
  - Write: commit the latched data to RAM on entry and set write_dn=1.
  - Read: data_out = RAM[idx] registered, and set read_dn=1.
  - Latency from the request-capture edge to dn high is WAIT_CYC+2 clk_oe cycles.
  - Hold dn (and data_out for reads) until the request drops.
- Four-phase handshake:
  - When the served request line goes 0, clear dn, clear data_out to 0, clear bus_busy_out, go to RELEASE.
  - Addr/data changes during WAIT/ACK are ignored because the values were latched at capture.
  - If the opposite request rises during ACK, it is ignored until the current request drops.
- Request withdrawn early: if the request drops during WAIT, abort, do not commit, go to RELEASE.
- RELEASE state: one dead cycle with dn low, then IDLE. This guarantees back-to-back requests see dn low for at least one cycle.
- clk_oe=0: all state and outputs hold.

Optional Feature:
- MEM_BUS_RESPONDER_STATS_EN defined:
  - Adds outputs rd_cnt and wr_cnt, each 16 bits.
  - Each counts completed transfers, incremented on the ACK entry edge.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include (alongside sizes.v/states.v):
  - FSM state encodings: IDLE=0, WAIT=1, ACK=2, RELEASE=3, each 2 bits.
  - The RESP_WAIT_W=4 constant.
- Sub-module: mem_bus_responder_ram.
  - Single-port synchronous RAM of DATA_W x 2**DEPTH_LOG2.
  - Registered read, write-enable.

Test Plan:
- Write then read:
  - write_q, addr=BASE+5, data=32'hDEADBEEF, WAIT_CYC=2 -> write_dn rises 4 cycles after capture.
  - Later read_q, addr=BASE+5 -> read_dn with data_out=32'hDEADBEEF; data_out=0 after read_q drops.
- Out of window: read_q, addr=BASE+256 and addr=BASE-1 -> no dn, bus_busy_out stays 0 for 20 cycles.
- Simultaneous requests: read_q=write_q=1, in-window -> no response. Then drop write_q -> the read is served normally.
- Early withdrawal: write_q dropped in WAIT with data 32'h1234 -> no write_dn; a following read of the same address returns the previous value.
- Reset in ACK: rst_n=0 while read_dn=1 -> next cycle all outputs 0, FSM in IDLE. Stats build: rd_cnt=0.
- clk_oe gating and WAIT_CYC=0:
  - clk_oe toggled 1/0 -> latency counts only enabled cycles.
  - WAIT_CYC=0 gives dn 2 enabled cycles after capture.
